pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline; sits beside the ID stage and drives the write-enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Consumes control bits already produced by the decoder (memRead, set_flags, branch resolution) plus register indices.
- Resolves load-use hazards, flag hazards (B.cond directly after ADDS/SUBS), taken-branch flushes and data-memory wait freezes.
- Uses a registered FSM with a stall down-counter.

Parameters:
LD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3); 2 when the MEM-stage forward path is disabled
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  reset; asynchronous, active-high
id_rn  in  5  Rn index of instruction in ID
id_rm  in  5  Rm/Rt index selected by Reg2Loc in ID
id_use_rn  in  1  ID instruction reads Rn
id_use_rm  in  1  ID instruction reads Rm/Rt
id_is_cond_br  in  1  ID instruction is B.cond
ex_rd  in  5  destination index in EX
ex_memRead  in  1  EX instruction is LDUR
ex_set_flags  in  1  EX instruction writes flags
ex_br_taken  in  1  branch resolved taken in EX (B, BL, BR, CBZ, B.cond)
mem_busy  in  1  data memory not ready; whole pipeline must hold
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to NOP at next edge
idex_bubble  out  1  load NOP control word into ID/EX at next edge
exmem_en  out  1  EX/MEM write enable
memwb_en  out  1  MEM/WB write enable
hz_state  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, STALL_LD=1, STALL_FLG=2, FREEZE=3. Registered. Outputs are combinational from state and inputs.
- Reset: state=RUN, stall_cnt=0, resume_state=RUN.
- Outputs while rst=1: all enables 1, all flush/bubble 0.
- XZR: index 31 never creates a hazard.
- Load-use condition: ex_memRead && ex_rd!=31 && ((id_use_rn && id_rn==ex_rd) || (id_use_rm && id_rm==ex_rd)).
- Per-cycle priority, highest first:
  1. mem_busy.
     - Outputs: pc_en=ifid_en=exmem_en=memwb_en=0, no flush, no bubble.
     - If state!=FREEZE: resume_state<=state, state<=FREEZE.
     - stall_cnt frozen.
  2. ex_br_taken.
     - Outputs: ifid_flush=1, idex_bubble=1, all enables 1.
     - state<=RUN, stall_cnt<=0. Aborts any pending stall.
  3. Load-use (state RUN).
     - Outputs: pc_en=ifid_en=0, idex_bubble=1.
     - If LD_STALL_CYCLES>1: state<=STALL_LD, stall_cnt<=LD_STALL_CYCLES-1.
     - If LD_STALL_CYCLES=1: state stays RUN.
  4. Flag hazard (state RUN): id_is_cond_br && ex_set_flags.
     - Outputs: pc_en=ifid_en=0, idex_bubble=1.
     - state<=STALL_FLG.
  5. Otherwise: all enables 1, no flush, no bubble.
- STALL_LD: pc_en=ifid_en=0, idex_bubble=1. stall_cnt decrements; state<=RUN when stall_cnt reaches 1.
- STALL_FLG: one cycle, outputs normal; the flag hazard check is suppressed this cycle. state<=RUN.
- FREEZE:
  - When mem_busy drops: state<=resume_state.
  - That cycle's outputs are computed as if in resume_state.
- Total load-use stall = exactly LD_STALL_CYCLES cycles of held PC.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt [CNT_W] and perf_flush_cnt [CNT_W].
  - perf_stall_cnt increments every cycle idex_bubble=1 without ifid_flush.
  - perf_flush_cnt increments per ex_br_taken cycle not masked by mem_busy.
  - Both saturate at all-ones; both reset to 0.
- When undefined: no counter ports or logic.

Decomposition:
- Shared package hazard_pkg:
  - state enum hz_state_t {RUN, STALL_LD, STALL_FLG, FREEZE}
  - localparam XZR = 5'd31
  - NOP control-word constant used by the ID/EX bubble mux
- One sub-module, hazard_detect (purely combinational): produces ld_use and flag_haz.

Test Plan:
1. Reset: rst=1 async mid-cycle -> hz_state=0, pc_en=1, no bubble; release -> RUN.
2. Load-use: ex_memRead=1, ex_rd=5, id_rn=5, id_use_rn=1, LD_STALL_CYCLES=2 -> pc_en=0 and idex_bubble=1 for exactly 2 cycles, then RUN. Same with ex_rd=31 -> no stall.
3. Flag hazard: ex_set_flags=1, id_is_cond_br=1 -> one bubble cycle, hz_state=2 next cycle, then 0.
4. Branch during stall: STALL_LD with stall_cnt=1, ex_br_taken=1 -> ifid_flush=1, idex_bubble=1, pc_en=1, state RUN.
5. Freeze: mem_busy=1 for 3 cycles during STALL_LD -> all enables 0 for 3 cycles, stall_cnt unchanged; release -> STALL_LD resumes with remaining count.
6. HAZ_PERF_CNT_EN: 2 load-use events plus 1 taken branch -> perf_stall_cnt=2×LD_STALL_CYCLES, perf_flush_cnt=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_LD  = 2'd1,
        STALL_FLG = 2'd2,
        FREEZE    = 2'd3
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       set_flags;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_word_t;

    // All-zero control word: no register, memory, flag or branch side effects.
    localparam ctrl_word_t NOP_CTRL = '0;

    localparam int STALL_CNT_W = 2;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and flag hazard detection
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_use_rn,
    input  logic       id_use_rm,
    input  logic       id_is_cond_br,
    input  logic [4:0] ex_rd,
    input  logic       ex_memRead,
    input  logic       ex_set_flags,
    output logic       ld_use,
    output logic       flag_haz
);

    logic rn_match;
    logic rm_match;

    always_comb begin
        rn_match = id_use_rn && (id_rn == ex_rd);
        rm_match = id_use_rm && (id_rm == ex_rd);
        // XZR reads as zero and discards writes, so it never carries a dependency.
        ld_use   = ex_memRead && (ex_rd != XZR) && (rn_match || rm_match);
        flag_haz = id_is_cond_br && ex_set_flags;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipeline
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LD_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_is_cond_br,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_set_flags,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [1:0]       hz_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam logic [STALL_CNT_W-1:0] LD_RELOAD = STALL_CNT_W'(LD_STALL_CYCLES - 1);

    hz_state_t              state_q, state_d;
    hz_state_t              resume_q, resume_d;
    hz_state_t              eff_state;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ld_use;
    logic flag_haz;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c, exmem_en_c, memwb_en_c;

    hazard_detect u_detect (
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_use_rn     (id_use_rn),
        .id_use_rm     (id_use_rm),
        .id_is_cond_br (id_is_cond_br),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .ex_set_flags  (ex_set_flags),
        .ld_use        (ld_use),
        .flag_haz      (flag_haz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            resume_q    <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        state_d       = state_q;
        resume_d      = resume_q;
        stall_cnt_d   = stall_cnt_q;
        // Leaving FREEZE behaves exactly like the state that was interrupted.
        eff_state     = (state_q == FREEZE) ? resume_q : state_q;

        if (mem_busy) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
            if (state_q != FREEZE) begin
                resume_d = state_q;
                state_d  = FREEZE;
            end
        end else if (ex_br_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = RUN;
            stall_cnt_d   = '0;
        end else begin
            case (eff_state)
                RUN: begin
                    state_d = RUN;
                    if (ld_use) begin
                        pc_en_c       = 1'b0;
                        ifid_en_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                        if (LD_STALL_CYCLES > 1) begin
                            state_d     = STALL_LD;
                            stall_cnt_d = LD_RELOAD;
                        end
                    end else if (flag_haz) begin
                        pc_en_c       = 1'b0;
                        ifid_en_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                        state_d       = STALL_FLG;
                    end
                end
                STALL_LD: begin
                    pc_en_c       = 1'b0;
                    ifid_en_c     = 1'b0;
                    idex_bubble_c = 1'b1;
                    if (stall_cnt_q <= STALL_CNT_W'(1)) begin
                        state_d     = RUN;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
                    end
                end
                STALL_FLG: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Reset forces a free-running pipeline regardless of the inputs.
    assign pc_en       = rst | pc_en_c;
    assign ifid_en     = rst | ifid_en_c;
    assign exmem_en    = rst | exmem_en_c;
    assign memwb_en    = rst | memwb_en_c;
    assign ifid_flush  = ~rst & ifid_flush_c;
    assign idex_bubble = ~rst & idex_bubble_c;
    assign hz_state    = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (idex_bubble_c && !ifid_flush_c && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
        if (ex_br_taken && !mem_busy && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with a reference model
module tb_pipeline_hazard_ctrl;

    localparam int LD = 2;
    localparam int CW = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_use_rn, id_use_rm, id_is_cond_br;
    logic       ex_memRead, ex_set_flags, ex_br_taken, mem_busy;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en;
    logic [1:0] hz_state;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LD_STALL_CYCLES(LD), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_use_rn     (id_use_rn),
        .id_use_rm     (id_use_rm),
        .id_is_cond_br (id_is_cond_br),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .ex_set_flags  (ex_set_flags),
        .ex_br_taken   (ex_br_taken),
        .mem_busy      (mem_busy),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .hz_state      (hz_state)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [5:0] outs;   // pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: pipeline held-cycle bookkeeping expressed as counts.
    int m_ld_left   = 0;
    bit m_flg       = 0;
    bit m_frozen    = 0;
    int m_stall_evt = 0;
    int m_flush_evt = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("outs", {2'b00, pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en},
                {2'b00, e.outs});
            chk("hz_state", {6'd0, hz_state}, {6'd0, e.st});
        end
    end

    task automatic drive(input logic r, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic cb,
                         input logic [4:0] rd, input logic mr, input logic sf,
                         input logic bt, input logic mb);
        exp_t e;
        bit   lu;
        bit   hold;
        bit   flush;
        @(posedge clk);
        #1;
        rst = r; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
        id_is_cond_br = cb; ex_rd = rd; ex_memRead = mr; ex_set_flags = sf;
        ex_br_taken = bt; mem_busy = mb;

        lu    = mr && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
        hold  = 0;
        flush = 0;
        if (r) begin
            m_ld_left = 0; m_flg = 0; m_frozen = 0; m_stall_evt = 0; m_flush_evt = 0;
            e.st   = 2'd0;
            e.outs = 6'b110011;
        end else begin
            e.st = m_frozen ? 2'd3 : (m_ld_left > 0) ? 2'd1 : m_flg ? 2'd2 : 2'd0;
            if (mb) begin
                m_frozen = 1;
                e.outs   = 6'b000000;
            end else begin
                m_frozen = 0;
                if (bt) begin
                    flush = 1; m_ld_left = 0; m_flg = 0; m_flush_evt++;
                end else if (m_ld_left > 0) begin
                    hold = 1; m_ld_left--;
                end else if (m_flg) begin
                    m_flg = 0;
                end else if (lu) begin
                    hold = 1; m_ld_left = LD - 1;
                end else if (cb && sf) begin
                    hold = 1; m_flg = 1;
                end
                if (hold) m_stall_evt++;
                e.outs = {~hold, ~hold, flush, hold | flush, 1'b1, 1'b1};
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] ridx();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    task automatic check_perf();
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt[7:0], 8'(m_stall_evt));
        chk("perf_flush_cnt", perf_flush_cnt[7:0], 8'(m_flush_evt));
`endif
    endtask

    initial begin
        rst = 1; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0; id_is_cond_br = 0;
        ex_rd = 0; ex_memRead = 0; ex_set_flags = 0; ex_br_taken = 0; mem_busy = 0;

        // Reset with hazard-looking inputs, then release.
        drive(1, 5, 5, 1, 0, 1, 5, 1, 1, 0, 0);
        drive(1, 3, 3, 1, 1, 0, 3, 1, 0, 1, 1);
        idle(2);

        // Load-use on Rn, then on Rm, then XZR destination.
        drive(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        idle(3);
        drive(0, 1, 7, 0, 1, 0, 7, 1, 0, 0, 0);
        idle(2);
        drive(0, 31, 31, 1, 1, 0, 31, 1, 0, 0, 0);
        idle(2);

        // Flag hazard.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        idle(3);

        // Taken branch in the last load-use stall cycle.
        drive(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Freeze for three cycles inside a load-use stall.
        drive(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Async reset mid-cycle out of a stall.
        drive(0, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        drive(1, 5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        idle(1);

        // Two load-use events and one taken branch from a fresh reset.
        drive(0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
        idle(2);
        drive(0, 0, 3, 0, 1, 0, 3, 1, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_dir", perf_stall_cnt[7:0], 8'(2 * LD));
        chk("perf_flush_dir", perf_flush_cnt[7:0], 8'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0), ridx(), ridx(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4), ridx(),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 15));
        end
        idle(4);
        check_perf();

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
